// File: rtl/mem_port_arbiter.sv
// Arbitrates one unified memory port between IF fetch and MEM load/store.
// Define MEM_ARB_FAIR_EN to add fetch-starvation protection.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_valid_o,
  output logic [DATA_W-1:0] i_data_o,
  output logic              i_stall_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_valid_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, RESP} state_e;

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  state_e            state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              i_valid_q;
  logic [DATA_W-1:0] i_data_q;
  logic              d_valid_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              fetch_win;
  logic              data_win;

`ifdef MEM_ARB_FAIR_EN
  logic [3:0] starve_q;
  logic [3:0] starve_d;

  // A waiting fetch overtakes data once it has been passed over StarveLimit times.
  assign fetch_win = i_req_i && (!d_req_i || (starve_q >= StarveLimit));

  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE) begin
      if (fetch_win) begin
        starve_d = '0;
      end else if (data_win && i_req_i && (starve_q != 4'hF)) begin
        starve_d = starve_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^StarveLimit;
  assign fetch_win = i_req_i && !d_req_i;
`endif

  assign data_win = d_req_i && !fetch_win;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      i_valid_q   <= 1'b0;
      i_data_q    <= '0;
      d_valid_q   <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (data_win) begin
            state_q     <= D_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
          end else if (fetch_win) begin
            state_q    <= I_BUSY;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= i_addr_i;
          end
        end
        I_BUSY, D_BUSY: begin
          // The memory port stays frozen until the ack; there is no timeout.
          if (mem_ack_i) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= RESP;
            if (state_q == I_BUSY) begin
              i_data_q  <= mem_rdata_i;
              i_valid_q <= 1'b1;
            end else begin
              d_rdata_q <= mem_rdata_i;
              d_valid_q <= 1'b1;
            end
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign i_valid_o   = i_valid_q;
  assign i_data_o    = i_data_q;
  assign d_valid_o   = d_valid_q;
  assign d_rdata_o   = d_rdata_q;

  // Stalls are combinational so the pipeline can release in the valid cycle itself.
  assign i_stall_o = i_req_i && !i_valid_q;
  assign d_stall_o = d_req_i && !d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// accesses against a variable-latency memory and a reference memory image.
module tb_mem_port_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FairEn = 1'b1;
`else
  localparam bit FairEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic              i_req_i;
  logic [ADDR_W-1:0] i_addr_i;
  logic              i_valid_o;
  logic [DATA_W-1:0] i_data_o;
  logic              i_stall_o;
  logic              d_req_i;
  logic              d_we_i;
  logic [ADDR_W-1:0] d_addr_i;
  logic [DATA_W-1:0] d_wdata_i;
  logic              d_valid_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  int vecCount = 0;
  int errCount = 0;

  // Memory environment: storage seen through the DUT port, and the bench's
  // own expectation of memory contents built from the issued requests.
  logic [31:0] memArr [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];
  int waitSet  = 0;
  int memWait  = 0;
  bit ackNoise = 1'b0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_valid_o(i_valid_o),
    .i_data_o(i_data_o), .i_stall_o(i_stall_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_valid_o(d_valid_o), .d_rdata_o(d_rdata_o),
    .d_stall_o(d_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  // Advance one clock and, #1 later, let the memory decide this cycle's ack.
  task automatic tick();
    @(posedge clk);
    #1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = $urandom;
    if (mem_req_o) begin
      if (memWait >= waitSet) begin
        mem_ack_i = 1'b1;
        if (mem_we_o) memArr[mem_addr_o] = mem_wdata_o;
        else mem_rdata_i = memArr.exists(mem_addr_o) ? memArr[mem_addr_o] : initWord(mem_addr_o);
      end else begin
        memWait++;
      end
    end else begin
      memWait = 0;
      if (ackNoise) mem_ack_i = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1; i_req_i = 1'b0; i_addr_i = '0; d_req_i = 1'b0; d_we_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    bit bad;
    do_reset();
    vecCount++;
    if ({mem_req_o, mem_we_o, i_valid_o, d_valid_o} !== 4'b0000) begin
      errCount++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000", {mem_req_o, mem_we_o, i_valid_o, d_valid_o});
    end
    vecCount++;
    if ((mem_addr_o | mem_wdata_o | i_data_o | d_rdata_o) !== 32'h0) begin
      errCount++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h idata=%h drdata=%h expected all 0",
               mem_addr_o, mem_wdata_o, i_data_o, d_rdata_o);
    end
    waitSet = 20;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h44;
    tick();
    vecCount++;
    if (mem_req_o !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL reset_busy_req: got %b expected 1", mem_req_o);
    end
    tick();
    rst_i = 1'b1;
    tick();
    vecCount++;
    if ({mem_req_o, i_valid_o, d_valid_o} !== 3'b000) begin
      errCount++;
      $display("[TB] FAIL reset_midflight: got %b expected 000", {mem_req_o, i_valid_o, d_valid_o});
    end
    tick();
    rst_i = 1'b0; d_req_i = 1'b0;
    ackNoise = 1'b1; waitSet = 0;
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if ({mem_req_o, i_valid_o, d_valid_o} !== 3'b000) bad = 1'b1;
    end
    ackNoise = 1'b0;
    vecCount++;
    if (bad) begin
      errCount++;
      $display("[TB] FAIL reset_stale_valid: got activity after abandoned access, expected none");
    end
  endtask

  task automatic test_single_fetch();
    memArr[32'h10] = 32'h8C22_0004;
    refMem[32'h10] = 32'h8C22_0004;
    waitSet = 0;
    i_req_i = 1'b1; i_addr_i = 32'h10;
    #1;
    vecCount++;
    if (i_stall_o !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL fetch_stall_t0: got %b expected 1", i_stall_o);
    end
    tick();
    vecCount++;
    if ({mem_req_o, mem_we_o, i_stall_o} !== 3'b101 || mem_addr_o !== 32'h10) begin
      errCount++;
      $display("[TB] FAIL fetch_t1: got req/we/stall=%b addr=%h expected 101 addr=00000010",
               {mem_req_o, mem_we_o, i_stall_o}, mem_addr_o);
    end
    tick();
    vecCount++;
    if (i_valid_o !== 1'b1 || i_stall_o !== 1'b0 || i_data_o !== 32'h8C22_0004) begin
      errCount++;
      $display("[TB] FAIL fetch_t2: got valid=%b stall=%b data=%h expected 1 0 8c220004",
               i_valid_o, i_stall_o, i_data_o);
    end
    i_req_i = 1'b0;
    tick();
    vecCount++;
    if (i_valid_o !== 1'b0 || i_data_o !== 32'h8C22_0004) begin
      errCount++;
      $display("[TB] FAIL fetch_hold: got valid=%b data=%h expected 0 8c220004", i_valid_o, i_data_o);
    end
  endtask

  // Generic single-requester access, checked for latency, data and stall.
  task automatic run_access(input bit isData, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int waitN);
    int lat;
    bit done;
    bit stallBad;
    bit otherBad;
    logic [31:0] expData;
    waitSet = waitN;
    expData = refRead(addr);
    if (isData) begin
      d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata;
    end else begin
      i_req_i = 1'b1; i_addr_i = addr;
    end
    lat = 0; done = 1'b0; stallBad = 1'b0; otherBad = 1'b0;
    while (!done && lat < 40) begin
      tick();
      lat++;
      done = isData ? d_valid_o : i_valid_o;
      if ((isData ? d_stall_o : i_stall_o) !== !done) stallBad = 1'b1;
      if ((isData ? i_valid_o : d_valid_o) !== 1'b0) otherBad = 1'b1;
    end
    vecCount++;
    if (!done || lat != 2 + waitN) begin
      errCount++;
      $display("[TB] FAIL access_latency: got %0d cycles (done=%b) expected %0d", lat, done, 2 + waitN);
    end
    vecCount++;
    if (stallBad || otherBad) begin
      errCount++;
      $display("[TB] FAIL access_stall_valid: got stallBad=%b otherValid=%b expected 0 0", stallBad, otherBad);
    end
    if (done && !(isData && we)) begin
      vecCount++;
      if ((isData ? d_rdata_o : i_data_o) !== expData) begin
        errCount++;
        $display("[TB] FAIL access_data: addr=%h got %h expected %h", addr,
                 isData ? d_rdata_o : i_data_o, expData);
      end
    end
    if (isData && we) refMem[addr] = wdata;
    d_req_i = 1'b0; i_req_i = 1'b0; d_we_i = 1'b0;
    tick();
  endtask

  task automatic test_store_wait();
    bit bad;
    waitSet = 3;
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h20; d_wdata_i = 32'hDEAD_BEEF;
    for (int k = 1; k <= 4; k++) begin
      tick();
      bad = !(mem_req_o === 1'b1 && mem_we_o === 1'b1 && mem_wdata_o === 32'hDEAD_BEEF &&
              mem_addr_o === 32'h20 && d_valid_o === 1'b0 && d_stall_o === 1'b1);
      vecCount++;
      if (bad) begin
        errCount++;
        $display("[TB] FAIL store_hold_t%0d: got req=%b we=%b addr=%h wdata=%h valid=%b expected 1 1 00000020 deadbeef 0",
                 k, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, d_valid_o);
      end
    end
    tick();
    vecCount++;
    if ({d_valid_o, d_stall_o, mem_req_o, mem_we_o} !== 4'b1000) begin
      errCount++;
      $display("[TB] FAIL store_done_t5: got valid/stall/req/we=%b expected 1000",
               {d_valid_o, d_stall_o, mem_req_o, mem_we_o});
    end
    refMem[32'h20] = 32'hDEAD_BEEF;
    d_req_i = 1'b0; d_we_i = 1'b0;
    tick();
    vecCount++;
    if (d_valid_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL store_pulse: got %b expected 0", d_valid_o);
    end
    run_access(1'b1, 1'b0, 32'h20, 32'h0, 1);
  endtask

  task automatic test_contention();
    logic [31:0] expD;
    logic [31:0] expI;
    waitSet = 0;
    expD = refRead(32'h24);
    expI = refRead(32'h100);
    i_req_i = 1'b1; i_addr_i = 32'h100;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h24;
    tick();
    vecCount++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h24 || mem_we_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL contend_t1: got req=%b addr=%h expected 1 00000024", mem_req_o, mem_addr_o);
    end
    tick();
    vecCount++;
    if (d_valid_o !== 1'b1 || d_rdata_o !== expD || i_valid_o !== 1'b0 || i_stall_o !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL contend_t2: got dvalid=%b rdata=%h ivalid=%b istall=%b expected 1 %h 0 1",
               d_valid_o, d_rdata_o, i_valid_o, i_stall_o, expD);
    end
    d_req_i = 1'b0;
    tick();
    vecCount++;
    if (mem_req_o !== 1'b0 || i_stall_o !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL contend_t3: got req=%b istall=%b expected 0 1", mem_req_o, i_stall_o);
    end
    tick();
    vecCount++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || i_stall_o !== 1'b1) begin
      errCount++;
      $display("[TB] FAIL contend_t4: got req=%b addr=%h istall=%b expected 1 00000100 1",
               mem_req_o, mem_addr_o, i_stall_o);
    end
    tick();
    vecCount++;
    if (i_valid_o !== 1'b1 || i_data_o !== expI || i_stall_o !== 1'b0) begin
      errCount++;
      $display("[TB] FAIL contend_t5: got ivalid=%b data=%h istall=%b expected 1 %h 0",
               i_valid_o, i_data_o, i_stall_o, expI);
    end
    i_req_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] addr;
    ackNoise = 1'b1;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      addr = 32'h200 + 32'(4 * $urandom_range(0, 7));
      run_access(kind != 0, kind == 2, addr, $urandom, $urandom_range(0, 3));
    end
    ackNoise = 1'b0;
  endtask

  task automatic test_fairness();
    int starve;
    int grants;
    int cyc;
    bit prevReq;
    bit expFetch;
    bit gotFetch;
    do_reset();
    waitSet = 0;
    i_req_i = 1'b1; i_addr_i = 32'h300;
    d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 32'h400;
    starve = 0; grants = 0; cyc = 0; prevReq = 1'b0;
    while (grants < 10 && cyc < 100) begin
      tick();
      cyc++;
      if (mem_req_o && !prevReq) begin
        expFetch = FairEn && (starve >= STARVE_LIMIT);
        if (expFetch) starve = 0;
        else if (starve < 15) starve++;
        gotFetch = (mem_addr_o === 32'h300);
        vecCount++;
        if (gotFetch !== expFetch) begin
          errCount++;
          $display("[TB] FAIL fair_grant%0d: got fetch=%b expected fetch=%b", grants, gotFetch, expFetch);
        end
        grants++;
      end
      prevReq = mem_req_o;
    end
    vecCount++;
    if (grants < 10) begin
      errCount++;
      $display("[TB] FAIL fair_timeout: got %0d grants expected 10", grants);
    end
    do_reset();
  endtask

  initial begin
    rst_i = 1'b1; i_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    i_addr_i = '0; d_addr_i = '0; d_wdata_i = '0;
    mem_ack_i = 1'b0; mem_rdata_i = '0;
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_contention();
    test_random();
    test_fairness();
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
